stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
- Parametrised successor to the team's skid buffer: a ring-buffer FIFO with full ready/valid handshaking on both sides.
- Adds upstream backpressure (in_ready), occupancy and threshold flags, a clearable sticky overflow flag, and a synchronous flush.
- Sits between streaming producers and consumers wherever the stall depth exceeds one word.

Parameters:
- DATA_SIZE, 16, payload width in bits.
- FIFO_DEPTH, 8, number of storage entries; any value >= 2, not required to be a power of two.
- ALMOST_FULL, FIFO_DEPTH-2, almost_full asserts when level >= ALMOST_FULL.
- ALMOST_EMPTY, 1, almost_empty asserts when level <= ALMOST_EMPTY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_SIZE  upstream payload.
- out_valid  out  1  word available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_SIZE  head payload.
- level  out  $clog2(FIFO_DEPTH+1)  stored word count, 0..FIFO_DEPTH.
- almost_full  out  1  level >= ALMOST_FULL.
- almost_empty  out  1  level <= ALMOST_EMPTY.
- overflow  out  1  sticky: a word was offered while in_ready=0.
- overflow_clr  in  1  synchronous clear of overflow.
- flush  in  1  synchronous discard of all contents.

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, level=0, overflow=0.
  - Outputs during reset: in_ready=0, out_valid=0, almost_empty=1, almost_full=0.
  - Storage contents are not reset.
  - in_ready rises combinationally once rst_n is high.
- Handshake events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = !full (full: level==FIFO_DEPTH). It never depends on out_ready, so there is no combinational ready path through the block.
  - When full, a same-cycle pop does not allow a push.
- Storage and pointers:
  - push writes mem[wr_ptr]; pop advances rd_ptr.
  - Each pointer wraps from FIFO_DEPTH-1 to 0.
  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Output (bypass disabled):
  - out_valid = (level != 0); out_data = mem[rd_ptr].
  - A pushed word is visible at the output on the next cycle (1-cycle latency).
- Output stability: while out_valid=1 and out_ready=0, out_valid and out_data hold, except on flush.
- Overflow:
  - in_valid & !in_ready sets overflow on the next edge; the word is dropped and level is unchanged.
  - overflow_clr clears overflow. If set and clear occur in the same cycle, set wins.
- Flush has priority over push, pop and overflow set:
  - Next state: rd_ptr=wr_ptr=0, level=0.
  - The push in the flush cycle is discarded.
  - out_valid is forced 0 during the flush cycle.
  - overflow is unaffected (only overflow_clr clears it).
- Flags are combinational from level; level is a register.
- Boundaries:
  - Empty + pop request: no-op.
  - Full + in_valid: drop and set overflow.
  - Full + pop: level becomes FIFO_DEPTH-1 and in_ready rises the next cycle.
  - Reset mid-transfer: all words discarded.

Optional Feature:
- Macro STREAM_FIFO_BYPASS_EN.
- Defined:
  - When level==0, out_valid=in_valid and out_data=in_data (zero-latency fall-through).
  - If out_ready=1 in that cycle, the word passes without being stored: pointers and level are unchanged.
  - If out_ready=0, the word is stored as a normal push.
  - Stability while stalled relies on upstream holding in_data.
  - flush still forces out_valid=0.
- Undefined: the registered 1-cycle-latency path only; no combinational in-to-out data path.

Test Plan:
- Reset then push 0x0001..0x0008 with out_ready=0, FIFO_DEPTH=8 -> level=8, in_ready=0, almost_full=1 from level 6; drain 8 words -> out_data 0x0001..0x0008 in order, level=0, almost_empty=1.
- Full FIFO, in_valid=1, in_data=0xDEAD for 1 cycle -> overflow=1 next cycle, level stays 8, 0xDEAD never appears at output. Then overflow_clr=1 together with another offered word -> overflow stays 1. Then overflow_clr alone -> overflow=0.
- Push and pop simultaneously for 20 cycles at level=3 -> level stays 3, pointers wrap past 7->0, output order preserved.
- Level=5, flush=1 with in_valid=1 -> next cycle level=0, out_valid=0, flushed word absent, overflow unchanged.
- Bypass defined: empty, in_valid=1, in_data=0x1234, out_ready=1 -> out_data=0x1234 same cycle, level stays 0. Bypass undefined: same stimulus -> out_valid=0 that cycle, 0x1234 appears the next cycle.
- Assert rst_n=0 at level=4 mid-stream -> in_ready=0 and out_valid=0 immediately; after release level=0 and in_ready=1.

Source files
------------

// File: rtl/stream_fifo.sv
// Ring-buffer stream FIFO with ready/valid on both sides, level/threshold flags,
// sticky overflow and synchronous flush. Define STREAM_FIFO_BYPASS_EN for zero-latency fall-through when empty.
module stream_fifo #(
    parameter int DATA_SIZE    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int ALMOST_FULL  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_SIZE-1:0]               in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_SIZE-1:0]               out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    input  logic                               overflow_clr,
    input  logic                               flush
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 empty_s, full_s, byp_s;
    logic                 push_s, pop_s, store_s, deq_s, mem_we_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign empty_s = (level_q == {LW{1'b0}});
    assign full_s  = (level_q == LVL_FULL);

`ifdef STREAM_FIFO_BYPASS_EN
    assign byp_s    = empty_s & in_valid & rst_n;
    assign out_data = empty_s ? in_data : mem_q[rd_ptr_q];
`else
    assign byp_s    = 1'b0;
    assign out_data = mem_q[rd_ptr_q];
`endif

    // in_ready is held low while reset is asserted and never looks at out_ready
    assign in_ready     = rst_n & ~full_s;
    assign out_valid    = ~flush & (~empty_s | byp_s);
    assign push_s       = in_valid & in_ready;
    assign pop_s        = out_valid & out_ready;
    assign store_s      = push_s & ~(byp_s & pop_s);
    assign deq_s        = pop_s & ~empty_s;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign almost_full  = (level_q >= LW'(ALMOST_FULL));
    assign almost_empty = (level_q <= LW'(ALMOST_EMPTY));

    // Next-state for pointers, level and overflow; flush overrides all traffic
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        mem_we_s   = 1'b0;
        if (flush) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
            if (overflow_clr) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            if (store_s) begin
                mem_we_s = 1'b1;
                wr_ptr_d = next_ptr(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({store_s, deq_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // set beats clear when both happen in one cycle
            if (in_valid & ~in_ready) begin
                overflow_d = 1'b1;
            end else if (overflow_clr) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DATA_SIZE=16, FIFO_DEPTH=8).
// Follows STREAM_FIFO_BYPASS_EN to pick the expected output timing.
module tb_stream_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        overflow_clr;
    logic        flush;

    int checks;
    int errors;

    stream_fifo #(.DATA_SIZE(16), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .flush        (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 16'h0000;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        flush        = 1'b0;

        // reset state
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // fill 1..8 with the consumer stalled
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i);
            tick();
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_almost_full", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);

        // drain in order
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(i));
            tick();
        end
        chk("drained_level", 32'(level), 32'd0);
        chk("drained_almost_empty", 32'(almost_empty), 32'd1);
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("empty_pop_noop", 32'(level), 32'd0);

        // overflow: fill, offer 0xDEAD, clear vs set, clear alone
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
        end
        in_data = 16'hDEAD;
        tick();
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        in_valid     = 1'b1;
        in_data      = 16'hBEEF;
        overflow_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("ovf_drain_data", 32'(out_data), 32'h0100 + 32'(i));
            tick();
        end
        chk("ovf_drained_level", 32'(level), 32'd0);

        // steady push+pop at level 3 across pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'h0200 + 16'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = 16'h0203 + 16'(k);
            #1;
            chk("stream_data", 32'(out_data), 32'h0200 + 32'(k));
            tick();
            chk("stream_level", 32'(level), 32'd3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stream_tail", 32'(out_data), 32'h0214 + 32'(i));
            tick();
        end
        chk("stream_empty", 32'(level), 32'd0);

        // flush at level 5 with overflow set and a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h0300 + 16'(i);
            tick();
        end
        in_data = 16'h03EE;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("full_pop_level", 32'(level), 32'd7);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        out_ready = 1'b0;
        chk("pre_flush_level", 32'(level), 32'd5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h03FF;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid_after", 32'(out_valid), 32'd0);
        chk("flush_ovf_kept", 32'(overflow), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h03AA;
        tick();
        in_valid = 1'b0;
        chk("post_flush_data", 32'(out_data), 32'h03AA);
        chk("post_flush_level", 32'(level), 32'd1);
        out_ready    = 1'b1;
        overflow_clr = 1'b1;
        tick();
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        chk("post_flush_empty", 32'(level), 32'd0);

        // empty FIFO, word offered with consumer ready
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        #1;
`ifdef STREAM_FIFO_BYPASS_EN
        chk("byp_out_valid", 32'(out_valid), 32'd1);
        chk("byp_out_data", 32'(out_data), 32'h1234);
        tick();
        in_valid = 1'b0;
        chk("byp_level", 32'(level), 32'd0);
        chk("byp_after_valid", 32'(out_valid), 32'd0);
`else
        chk("nobyp_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("nobyp_next_valid", 32'(out_valid), 32'd1);
        chk("nobyp_next_data", 32'(out_data), 32'h1234);
        chk("nobyp_level", 32'(level), 32'd1);
        tick();
        chk("nobyp_drained", 32'(level), 32'd0);
`endif

        // asynchronous reset mid-stream at level 4
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h0400 + 16'(i);
            tick();
        end
        chk("pre_rst_level", 32'(level), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_level", 32'(level), 32'd0);
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
